// File: rtl/flag_context_stack_if.sv
// Control-unit <-> flag context stack bundle: push/pop requests in, restored flags and status out.
interface flag_context_stack_if #(
    parameter int DEPTH  = 4,
    parameter int FLAG_W = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              INT_TAKEN;
    logic              RETIE;
    logic [FLAG_W-1:0] FLG_IN;
    logic              ERR_CLR;
    logic [FLAG_W-1:0] FLG_OUT;
    logic              FLG_LD;
    logic [CW-1:0]     DEPTH_CNT;
    logic              FULL;
    logic              EMPTY;
    logic              OVF_ERR;
    logic              UNF_ERR;

    modport master (
        output INT_TAKEN, RETIE, FLG_IN, ERR_CLR,
        input  FLG_OUT, FLG_LD, DEPTH_CNT, FULL, EMPTY, OVF_ERR, UNF_ERR
    );

    modport slave (
        input  INT_TAKEN, RETIE, FLG_IN, ERR_CLR,
        output FLG_OUT, FLG_LD, DEPTH_CNT, FULL, EMPTY, OVF_ERR, UNF_ERR
    );
endinterface

// File: rtl/flag_context_stack.sv
// LIFO of {Z,C} flag contexts saved on interrupt entry and restored on RETIE with a one-cycle load strobe.
// Optional sticky overflow/underflow errors are enabled by defining FLAG_CTX_ERR_EN.
module flag_context_stack #(
    parameter int DEPTH  = 4,
    parameter int FLAG_W = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    flag_context_stack_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, RESTORE} state_t;

    state_t            state, state_nxt;
    logic [FLAG_W-1:0] mem [DEPTH];
    logic [CW-1:0]     cnt;
    logic [FLAG_W-1:0] out_q;
    logic              flg_ld;
    logic              full, empty;
    logic              pop_ok, push_ok, ovf_evt, unf_evt;
    logic [AW-1:0]     top_idx, wr_idx;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign pop_ok  = bus.RETIE & ~empty;
    // A pop on an empty stack falls through, so a simultaneous push still lands.
    assign push_ok = bus.INT_TAKEN & ~pop_ok & ~full;
    assign ovf_evt = bus.INT_TAKEN & ~bus.RETIE & full;
    assign unf_evt = bus.RETIE & empty;
    assign top_idx = AW'(cnt - CW'(1));
    assign wr_idx  = AW'(cnt);

    // NOTE: storage has no reset; its contents are never observed while the count says empty.
    always_ff @(posedge CLK) begin
        if (pop_ok && bus.INT_TAKEN)
            mem[top_idx] <= bus.FLG_IN;
        else if (push_ok)
            mem[wr_idx] <= bus.FLG_IN;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt   <= '0;
            out_q <= '0;
        end else if (pop_ok) begin
            out_q <= mem[top_idx];
            if (!bus.INT_TAKEN)
                cnt <= cnt - CW'(1);
        end else if (push_ok) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_nxt = IDLE;
        flg_ld    = 1'b0;
        case (state)
            IDLE:    if (pop_ok) state_nxt = RESTORE;
            RESTORE: begin
                flg_ld = 1'b1;
                if (pop_ok) state_nxt = RESTORE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.FLG_OUT   = out_q;
    assign bus.FLG_LD    = flg_ld;
    assign bus.DEPTH_CNT = cnt;
    assign bus.FULL      = full;
    assign bus.EMPTY     = empty;

`ifdef FLAG_CTX_ERR_EN
    logic ovf_q, unf_q;

    // A same-cycle event beats the clear so no error is ever lost.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_evt)          ovf_q <= 1'b1;
            else if (bus.ERR_CLR) ovf_q <= 1'b0;
            if (unf_evt)          unf_q <= 1'b1;
            else if (bus.ERR_CLR) unf_q <= 1'b0;
        end
    end

    assign bus.OVF_ERR = ovf_q;
    assign bus.UNF_ERR = unf_q;
`else
    logic unused_err;
    assign unused_err  = ^{bus.ERR_CLR, ovf_evt, unf_evt};
    assign bus.OVF_ERR = 1'b0;
    assign bus.UNF_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_flag_context_stack.sv
// Bench for flag_context_stack: directed scenarios plus random traffic against a queue-based LIFO model.
module tb_flag_context_stack;
    localparam int DEPTH  = 4;
    localparam int FLAG_W = 2;
`ifdef FLAG_CTX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    flag_context_stack_if #(.DEPTH(DEPTH), .FLAG_W(FLAG_W)) bus ();
    flag_context_stack #(.DEPTH(DEPTH), .FLAG_W(FLAG_W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [FLAG_W-1:0] q [$];
    logic              exp_ld;
    logic [FLAG_W-1:0] exp_out;
    logic              exp_ovf, exp_unf;

    // One clock with the given inputs; the reference model steps alongside.
    task automatic drive_cycle(input logic rn, input logic it, input logic re,
                               input logic [FLAG_W-1:0] fin, input logic clr);
        int sz;
        bit ovf_e, unf_e;
        RST_N         = rn;
        bus.INT_TAKEN = it;
        bus.RETIE     = re;
        bus.FLG_IN    = fin;
        bus.ERR_CLR   = clr;
        @(posedge CLK);
        sz = q.size();
        if (!rn) begin
            q.delete();
            exp_ld  = 1'b0;
            exp_out = '0;
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            exp_ld = 1'b0;
            ovf_e  = it && !re && sz == DEPTH;
            unf_e  = re && sz == 0;
            if (re && sz > 0) begin
                exp_out = q.pop_back();
                exp_ld  = 1'b1;
                if (it) q.push_back(fin);
            end else if (it && sz < DEPTH) begin
                q.push_back(fin);
            end
            if (ERR_EN) begin
                exp_ovf = ovf_e | (exp_ovf & ~clr);
                exp_unf = unf_e | (exp_unf & ~clr);
            end
        end
        #1;
    endtask

    task automatic idle();
        drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        drive_cycle(1'b0, 1'b1, 1'b1, 2'b11, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if ({bus.DEPTH_CNT, bus.EMPTY, bus.FULL, bus.FLG_LD, bus.FLG_OUT, bus.OVF_ERR, bus.UNF_ERR} !== 10'b000_1_0_0_00_0_0) begin
            miscompares++;
            $display("FAIL reset_state: cnt=%0d empty=%b full=%b ld=%b out=%b ovf=%b unf=%b, required cnt=0 empty=1 others 0",
                     bus.DEPTH_CNT, bus.EMPTY, bus.FULL, bus.FLG_LD, bus.FLG_OUT, bus.OVF_ERR, bus.UNF_ERR);
        end
    endtask

    task automatic test_single();
        drive_cycle(1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
        vectors++;
        if (bus.DEPTH_CNT !== 3'd1 || bus.EMPTY !== 1'b0) begin
            miscompares++;
            $display("FAIL single_push: cnt=%0d empty=%b, required cnt=1 empty=0", bus.DEPTH_CNT, bus.EMPTY);
        end
        drive_cycle(1'b1, 1'b0, 1'b1, '0, 1'b0);
        vectors++;
        if ({bus.FLG_LD, bus.FLG_OUT, bus.DEPTH_CNT, bus.EMPTY} !== 7'b1_01_000_1) begin
            miscompares++;
            $display("FAIL single_pop: ld=%b out=%b cnt=%0d empty=%b, required ld=1 out=01 cnt=0 empty=1",
                     bus.FLG_LD, bus.FLG_OUT, bus.DEPTH_CNT, bus.EMPTY);
        end
        idle();
        vectors++;
        if (bus.FLG_LD !== 1'b0 || bus.FLG_OUT !== 2'b01) begin
            miscompares++;
            $display("FAIL single_hold: ld=%b out=%b, required ld=0 out=01", bus.FLG_LD, bus.FLG_OUT);
        end
    endtask

    task automatic test_nesting();
        logic [FLAG_W-1:0] pushes [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b1, 1'b0, pushes[i], 1'b0);
        vectors++;
        if (bus.FULL !== 1'b1 || bus.DEPTH_CNT !== 3'd4) begin
            miscompares++;
            $display("FAIL nest_full: full=%b cnt=%0d, required full=1 cnt=4", bus.FULL, bus.DEPTH_CNT);
        end
        for (int i = 3; i >= 0; i--) begin
            drive_cycle(1'b1, 1'b0, 1'b1, '0, 1'b0);
            vectors++;
            if (bus.FLG_LD !== 1'b1 || bus.FLG_OUT !== pushes[i]) begin
                miscompares++;
                $display("FAIL nest_pop%0d: ld=%b out=%b, required ld=1 out=%b", 3 - i, bus.FLG_LD, bus.FLG_OUT, pushes[i]);
            end
        end
        vectors++;
        if (bus.EMPTY !== 1'b1) begin
            miscompares++;
            $display("FAIL nest_empty: empty=%b, required 1", bus.EMPTY);
        end
        idle();
    endtask

    task automatic test_overflow();
        logic [FLAG_W-1:0] pushes [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b1, 1'b0, pushes[i], 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
        vectors++;
        if (bus.DEPTH_CNT !== 3'd4 || bus.OVF_ERR !== ERR_EN) begin
            miscompares++;
            $display("FAIL ovf_push: cnt=%0d ovf=%b, required cnt=4 ovf=%b", bus.DEPTH_CNT, bus.OVF_ERR, ERR_EN);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (bus.OVF_ERR !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: ovf=%b, required 0", bus.OVF_ERR);
        end
        drive_cycle(1'b1, 1'b0, 1'b1, '0, 1'b0);
        vectors++;
        if (bus.FLG_LD !== 1'b1 || bus.FLG_OUT !== 2'b00) begin
            miscompares++;
            $display("FAIL ovf_top: ld=%b out=%b, required ld=1 out=00", bus.FLG_LD, bus.FLG_OUT);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_underflow();
        drive_cycle(1'b1, 1'b0, 1'b1, '0, 1'b0);
        vectors++;
        if (bus.FLG_LD !== 1'b0 || bus.DEPTH_CNT !== 3'd0 || bus.UNF_ERR !== ERR_EN) begin
            miscompares++;
            $display("FAIL unf_pop: ld=%b cnt=%0d unf=%b, required ld=0 cnt=0 unf=%b",
                     bus.FLG_LD, bus.DEPTH_CNT, bus.UNF_ERR, ERR_EN);
        end
        drive_cycle(1'b1, 1'b0, 1'b1, '0, 1'b1);
        vectors++;
        if (bus.UNF_ERR !== ERR_EN || bus.FLG_LD !== 1'b0) begin
            miscompares++;
            $display("FAIL unf_clr_race: unf=%b ld=%b, required unf=%b ld=0", bus.UNF_ERR, bus.FLG_LD, ERR_EN);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (bus.UNF_ERR !== 1'b0) begin
            miscompares++;
            $display("FAIL unf_clear: unf=%b, required 0", bus.UNF_ERR);
        end
        // Push+pop on empty: the push lands, no strobe.
        drive_cycle(1'b1, 1'b1, 1'b1, 2'b10, 1'b0);
        vectors++;
        if (bus.DEPTH_CNT !== 3'd1 || bus.FLG_LD !== 1'b0 || bus.UNF_ERR !== ERR_EN) begin
            miscompares++;
            $display("FAIL unf_simul: cnt=%0d ld=%b unf=%b, required cnt=1 ld=0 unf=%b",
                     bus.DEPTH_CNT, bus.FLG_LD, bus.UNF_ERR, ERR_EN);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_simultaneous();
        logic [FLAG_W-1:0] pops [2] = '{2'b11, 2'b01};
        drive_cycle(1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b1, 2'b11, 1'b0);
        vectors++;
        if ({bus.FLG_LD, bus.FLG_OUT, bus.DEPTH_CNT} !== 6'b1_10_010) begin
            miscompares++;
            $display("FAIL simul_swap: ld=%b out=%b cnt=%0d, required ld=1 out=10 cnt=2",
                     bus.FLG_LD, bus.FLG_OUT, bus.DEPTH_CNT);
        end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b1, '0, 1'b0);
            vectors++;
            if (bus.FLG_LD !== 1'b1 || bus.FLG_OUT !== pops[i]) begin
                miscompares++;
                $display("FAIL simul_pop%0d: ld=%b out=%b, required ld=1 out=%b", i, bus.FLG_LD, bus.FLG_OUT, pops[i]);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_restore();
        drive_cycle(1'b1, 1'b0, 1'b1, '0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b1, '0, 1'b0);
        vectors++;
        if (bus.FLG_LD !== 1'b1 || bus.FLG_OUT !== 2'b10) begin
            miscompares++;
            $display("FAIL midrst_pre: ld=%b out=%b, required ld=1 out=10", bus.FLG_LD, bus.FLG_OUT);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, '0, 1'b0);
        vectors++;
        if ({bus.FLG_LD, bus.DEPTH_CNT, bus.FLG_OUT, bus.OVF_ERR, bus.UNF_ERR} !== 8'b0_000_00_0_0) begin
            miscompares++;
            $display("FAIL midrst: ld=%b cnt=%0d out=%b ovf=%b unf=%b, required all 0",
                     bus.FLG_LD, bus.DEPTH_CNT, bus.FLG_OUT, bus.OVF_ERR, bus.UNF_ERR);
        end
    endtask

    task automatic test_random();
        logic [9:0] obs, exp;
        logic it, re, clr, rn;
        for (int n = 0; n < 600; n++) begin
            rn  = ($urandom_range(0, 79) != 0);
            it  = ($urandom_range(0, 99) < 45);
            re  = ($urandom_range(0, 99) < 40);
            clr = ($urandom_range(0, 15) == 0);
            drive_cycle(rn, it, re, FLAG_W'($urandom), clr);
            obs = {bus.FLG_LD, bus.FLG_OUT, bus.DEPTH_CNT, bus.FULL, bus.EMPTY, bus.OVF_ERR, bus.UNF_ERR};
            exp = {exp_ld, exp_out, 3'(q.size()), q.size() == DEPTH, q.size() == 0, exp_ovf, exp_unf};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL random[%0d] {ld,out,cnt,full,empty,ovf,unf}: got %b required %b", n, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_nesting();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_reset_mid_restore();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
